// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states, the bubble
// instruction and the IF/ID pipeline register layout.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    function automatic ifid_t ifid_bubble(input logic [31:0] nop);
        ifid_t b;
        b.instr = nop;
        b.pc    = 32'h0;
        b.pc4   = 32'h0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched instruction and its PC while
// decode is stalled. clear wins over load, load wins over take.
module fetch_skid (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic        take,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        full,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    logic        full_reg;
    logic [31:0] instr_reg;
    logic [31:0] pc_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_reg  <= 1'b0;
            instr_reg <= 32'h0;
            pc_reg    <= 32'h0;
        end else if (clear) begin
            full_reg <= 1'b0;
        end else if (load) begin
            full_reg  <= 1'b1;
            instr_reg <= load_instr;
            pc_reg    <= load_pc;
        end else if (take) begin
            full_reg <= 1'b0;
        end
    end

    assign full  = full_reg;
    assign instr = instr_reg;
    assign pc    = pc_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues one instruction-memory request at a time, owns the
// fetch PC and the IF/ID register, and applies decode stalls and EX redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic        pc_write,
    output logic [31:0] instrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        validD
);

    import fetch_pkg::*;

    state_t      state_reg, state_next;
    logic [31:0] pc_f_reg, pc_f_next;
    logic [31:0] pc_inflight_reg;
    ifid_t       ifid_reg, ifid_next;

    logic        req_fire;
    logic        resp_accept;
    logic        skid_load;
    logic        skid_take;
    logic        skid_full;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    fetch_skid u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .clear      (redirect),
        .take       (skid_take),
        .load_instr (imem_rdata),
        .load_pc    (pc_inflight_reg),
        .full       (skid_full),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    // State register, fetch PC, in-flight PC and IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            pc_f_reg        <= RESET_PC;
            pc_inflight_reg <= 32'h0;
            ifid_reg        <= ifid_bubble(NOP_INSTR);
        end else begin
            state_reg <= state_next;
            pc_f_reg  <= pc_f_next;
            ifid_reg  <= ifid_next;
            if (req_fire) begin
                pc_inflight_reg <= pc_f_reg;
            end
        end
    end

    // Next-state logic. A granted request whose response is still pending
    // must be drained after a redirect so its data never reaches IF/ID.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:  state_next = REQ;
            REQ: begin
                if (imem_gnt)      state_next = redirect ? DRAIN : WAIT;
                else               state_next = REQ;
            end
            WAIT: begin
                if (redirect)      state_next = imem_rvalid ? REQ : DRAIN;
                else if (imem_rvalid) state_next = stall_d ? HOLD : REQ;
            end
            HOLD: begin
                if (redirect || !stall_d) state_next = REQ;
            end
            DRAIN: begin
                if (imem_rvalid)   state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output and datapath-control logic.
    always_comb begin
        imem_req    = (state_reg == REQ);
        req_fire    = imem_req && imem_gnt;
        pc_write    = redirect || req_fire;
        resp_accept = (state_reg == WAIT) && imem_rvalid && !redirect;
        skid_load   = resp_accept && stall_d;
        skid_take   = (state_reg == HOLD) && skid_full && !stall_d && !redirect;

        pc_f_next = pc_f_reg;
        if (redirect)      pc_f_next = redirect_pc;
        else if (req_fire) pc_f_next = pc_f_reg + 32'd4;

        ifid_next = ifid_reg;
        if (redirect) begin
            ifid_next = ifid_bubble(NOP_INSTR);
        end else if (!stall_d) begin
            if (resp_accept) begin
                ifid_next.instr = imem_rdata;
                ifid_next.pc    = pc_inflight_reg;
                ifid_next.pc4   = pc_inflight_reg + 32'd4;
                ifid_next.valid = 1'b1;
            end else if (skid_take) begin
                ifid_next.instr = skid_instr;
                ifid_next.pc    = skid_pc;
                ifid_next.pc4   = skid_pc + 32'd4;
                ifid_next.valid = 1'b1;
            end else begin
                ifid_next = ifid_bubble(NOP_INSTR);
            end
        end
    end

    assign imem_addr = pc_f_reg;
    assign pc_f      = pc_f_reg;
    assign instrD    = ifid_reg.instr;
    assign PCD       = ifid_reg.pc;
    assign PCPlus4D  = ifid_reg.pc4;
    assign validD    = ifid_reg.valid;

endmodule
